nv_nvdla_pdp_core_med1d_lut_sched: RTL and testbench

//  Time-shares one NV_NVDLA_PDP_CORE_med1d_lut instance between NREQ encode requesters and one decode requester in the PDP median-1D path.

---
 rtl/nv_nvdla_pdp_core_med1d_lut_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_nv_nvdla_pdp_core_med1d_lut_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_pdp_core_med1d_lut_sched.sv
`default_nettype none
// ============================================================================
//  Module   : nv_nvdla_pdp_core_med1d_lut_sched
//  Purpose  : Time-shares one med1d LUT between NREQ encode requesters and a
//             single decode requester. Grants at most one request per cycle,
//             steers it onto the LUT and registers the LUT result into a
//             one-entry response slot tagged with the requester id.
//  Revision : 1.0  initial release
// ============================================================================
module nv_nvdla_pdp_core_med1d_lut_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic [NREQ-1:0]     enc_req_valid,
    output logic [NREQ-1:0]     enc_req_ready,
    input  logic [NREQ*9-1:0]   enc_req_msbs,
    input  logic                dec_req_valid,
    output logic                dec_req_ready,
    input  logic [27:0]         dec_req_idx,
    output logic                lut_encoding,
    output logic                lut_decoding,
    output logic [2:0]          lut_msb_a,
    output logic [2:0]          lut_msb_b,
    output logic [2:0]          lut_msb_c,
    output logic [27:0]         lut_to_decode,
    input  logic [6:0]          lut_code,
    input  logic [11:0]         lut_dec_i,
    input  logic [11:0]         lut_dec_j,
    input  logic [11:0]         lut_dec_k,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_is_dec,
    output logic [IDW-1:0]      rsp_id,
    output logic [6:0]          rsp_code,
    output logic [11:0]         rsp_msb_i,
    output logic [11:0]         rsp_msb_j,
    output logic [11:0]         rsp_msb_k,
    output logic [3:0]          rsp_err,
    output logic [15:0]         enc_cnt,
    output logic [15:0]         dec_cnt
);

    localparam int         PW        = $clog2(NREQ);
    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;
    localparam logic [6:0] MAX_INDEX = 7'd119;

    logic [0:0]     state_q, state_d;
    logic [PW-1:0]  rr_ptr_q;
    logic           dec_turn_q;
    logic [15:0]    enc_cnt_q, dec_cnt_q;

    logic           rsp_is_dec_q, rsp_is_dec_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [6:0]     rsp_code_q, rsp_code_d;
    logic [11:0]    rsp_i_q, rsp_i_d;
    logic [11:0]    rsp_j_q, rsp_j_d;
    logic [11:0]    rsp_k_q, rsp_k_d;
    logic [3:0]     rsp_err_q, rsp_err_d;

    logic           can_grant;
    logic           enc_any;
    logic           grant_enc, grant_dec, contested;
    logic [PW-1:0]  enc_win, enc_win_hi, enc_win_lo;
    logic           found_hi;
    logic [8:0]     enc_sel;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall
    always_comb begin
        enc_win_hi = '0;
        enc_win_lo = '0;
        found_hi   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (enc_req_valid[i]) begin
                enc_win_lo = PW'(i);
                if (PW'(i) >= rr_ptr_q) begin
                    enc_win_hi = PW'(i);
                    found_hi   = 1'b1;
                end
            end
        end
        enc_win = found_hi ? enc_win_hi : enc_win_lo;
    end

    // Select the winning requester's MSB triplet
    always_comb begin
        enc_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == enc_win) begin
                enc_sel = enc_req_msbs[9*i +: 9];
            end
        end
    end

    // Encode/decode arbitration; dec_turn breaks ties when both sides are pending
    always_comb begin
        enc_any   = |enc_req_valid;
        can_grant = !nvdla_core_rst && ((state_q == ST_EMPTY) || rsp_ready);
        grant_dec = can_grant && dec_req_valid && (!enc_any || dec_turn_q);
        grant_enc = can_grant && enc_any && (!dec_req_valid || !dec_turn_q);
        contested = can_grant && dec_req_valid && enc_any;
    end

    // FSM state register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: slot fills on a grant, empties when drained with no new grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant_enc || grant_dec) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (rsp_ready && !(grant_enc || grant_dec)) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // FSM outputs: grant strobes and LUT drive, all held at zero outside a grant
    always_comb begin
        enc_req_ready = '0;
        dec_req_ready = 1'b0;
        lut_encoding  = 1'b0;
        lut_decoding  = 1'b0;
        lut_msb_a     = 3'd0;
        lut_msb_b     = 3'd0;
        lut_msb_c     = 3'd0;
        lut_to_decode = 28'd0;
        if (grant_enc) begin
            for (int i = 0; i < NREQ; i++) begin
                enc_req_ready[i] = (PW'(i) == enc_win);
            end
            lut_encoding = 1'b1;
            {lut_msb_a, lut_msb_b, lut_msb_c} = enc_sel;
        end
        if (grant_dec) begin
            dec_req_ready = 1'b1;
            lut_decoding  = 1'b1;
            lut_to_decode = dec_req_idx;
        end
    end

    // Next response payload: LUT result of this cycle's grant, otherwise hold
    always_comb begin
        rsp_is_dec_d = rsp_is_dec_q;
        rsp_id_d     = rsp_id_q;
        rsp_code_d   = rsp_code_q;
        rsp_i_d      = rsp_i_q;
        rsp_j_d      = rsp_j_q;
        rsp_k_d      = rsp_k_q;
        rsp_err_d    = rsp_err_q;
        if (grant_enc) begin
            rsp_is_dec_d = 1'b0;
            rsp_id_d     = IDW'(enc_win);
            rsp_code_d   = lut_code;
            rsp_i_d      = 12'd0;
            rsp_j_d      = 12'd0;
            rsp_k_d      = 12'd0;
            rsp_err_d    = 4'd0;
        end else if (grant_dec) begin
            rsp_is_dec_d = 1'b1;
            rsp_id_d     = '0;
            rsp_code_d   = 7'd0;
            for (int n = 0; n < 4; n++) begin
                // Indices past the last LUT entry are flagged and the lane zeroed
                rsp_err_d[n]       = (dec_req_idx[7*n +: 7] > MAX_INDEX);
                rsp_i_d[3*n +: 3]  = rsp_err_d[n] ? 3'd0 : lut_dec_i[3*n +: 3];
                rsp_j_d[3*n +: 3]  = rsp_err_d[n] ? 3'd0 : lut_dec_j[3*n +: 3];
                rsp_k_d[3*n +: 3]  = rsp_err_d[n] ? 3'd0 : lut_dec_k[3*n +: 3];
            end
        end
    end

    // Response slot payload register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rsp_is_dec_q <= 1'b0;
            rsp_id_q     <= '0;
            rsp_code_q   <= 7'd0;
            rsp_i_q      <= 12'd0;
            rsp_j_q      <= 12'd0;
            rsp_k_q      <= 12'd0;
            rsp_err_q    <= 4'd0;
        end else begin
            rsp_is_dec_q <= rsp_is_dec_d;
            rsp_id_q     <= rsp_id_d;
            rsp_code_q   <= rsp_code_d;
            rsp_i_q      <= rsp_i_d;
            rsp_j_q      <= rsp_j_d;
            rsp_k_q      <= rsp_k_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Arbitration state and saturating grant counters
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            rr_ptr_q   <= '0;
            dec_turn_q <= 1'b0;
            enc_cnt_q  <= 16'd0;
            dec_cnt_q  <= 16'd0;
        end else begin
            if (grant_enc) begin
                rr_ptr_q <= (enc_win == PW'(NREQ - 1)) ? '0 : enc_win + PW'(1);
            end
            if (contested) begin
                dec_turn_q <= !dec_turn_q;
            end
            if (grant_enc && (enc_cnt_q != 16'hFFFF)) begin
                enc_cnt_q <= enc_cnt_q + 16'd1;
            end
            if (grant_dec && (dec_cnt_q != 16'hFFFF)) begin
                dec_cnt_q <= dec_cnt_q + 16'd1;
            end
        end
    end

    assign rsp_valid  = (state_q == ST_FULL);
    assign rsp_is_dec = rsp_is_dec_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_code   = rsp_code_q;
    assign rsp_msb_i  = rsp_i_q;
    assign rsp_msb_j  = rsp_j_q;
    assign rsp_msb_k  = rsp_k_q;
    assign rsp_err    = rsp_err_q;
    assign enc_cnt    = enc_cnt_q;
    assign dec_cnt    = dec_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_pdp_core_med1d_lut_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nv_nvdla_pdp_core_med1d_lut_sched
//  Purpose  : Scoreboard bench for the med1d LUT scheduler with a LUT model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nv_nvdla_pdp_core_med1d_lut_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    enc_req_valid = '0;
    logic [NREQ-1:0]    enc_req_ready;
    logic [NREQ*9-1:0]  enc_req_msbs = '0;
    logic               dec_req_valid = 1'b0;
    logic               dec_req_ready;
    logic [27:0]        dec_req_idx = '0;
    logic               lut_encoding, lut_decoding;
    logic [2:0]         lut_msb_a, lut_msb_b, lut_msb_c;
    logic [27:0]        lut_to_decode;
    logic [6:0]         lut_code;
    logic [11:0]        lut_dec_i, lut_dec_j, lut_dec_k;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_is_dec;
    logic [IDW-1:0]     rsp_id;
    logic [6:0]         rsp_code;
    logic [11:0]        rsp_msb_i, rsp_msb_j, rsp_msb_k;
    logic [3:0]         rsp_err;
    logic [15:0]        enc_cnt, dec_cnt;

    nv_nvdla_pdp_core_med1d_lut_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .enc_req_valid  (enc_req_valid),
        .enc_req_ready  (enc_req_ready),
        .enc_req_msbs   (enc_req_msbs),
        .dec_req_valid  (dec_req_valid),
        .dec_req_ready  (dec_req_ready),
        .dec_req_idx    (dec_req_idx),
        .lut_encoding   (lut_encoding),
        .lut_decoding   (lut_decoding),
        .lut_msb_a      (lut_msb_a),
        .lut_msb_b      (lut_msb_b),
        .lut_msb_c      (lut_msb_c),
        .lut_to_decode  (lut_to_decode),
        .lut_code       (lut_code),
        .lut_dec_i      (lut_dec_i),
        .lut_dec_j      (lut_dec_j),
        .lut_dec_k      (lut_dec_k),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_is_dec     (rsp_is_dec),
        .rsp_id         (rsp_id),
        .rsp_code       (rsp_code),
        .rsp_msb_i      (rsp_msb_i),
        .rsp_msb_j      (rsp_msb_j),
        .rsp_msb_k      (rsp_msb_k),
        .rsp_err        (rsp_err),
        .enc_cnt        (enc_cnt),
        .dec_cnt        (dec_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_dec;
        logic [2:0]  id;
        logic [6:0]  code;
        logic [11:0] i, j, k;
        logic [3:0]  err;
    } rsp_t;

    rsp_t sb[$];
    int   dut_log[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    bit   m_full = 0;
    int   m_rr = 0;
    bit   m_turn = 0;
    int   m_enc = 0;
    int   m_dec = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // LUT contents: multisets {k<=j<=i} of 3-bit values, enumerated in order
    function automatic int lut_index(input int a, input int b, input int c);
        int s0, s1, s2, t, n;
        s0 = a; s1 = b; s2 = c;
        if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
        if (s1 > s2) begin t = s1; s1 = s2; s2 = t; end
        if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
        n = 0;
        for (int k = 0; k < 8; k++)
            for (int j = k; j < 8; j++)
                for (int i = j; i < 8; i++) begin
                    if (k == s0 && j == s1 && i == s2) return n;
                    n++;
                end
        return 0;
    endfunction

    function automatic void lut_entry(input int idx, output int ek, output int ej, output int ei);
        int n;
        n = 0; ek = 0; ej = 0; ei = 0;
        for (int k = 0; k < 8; k++)
            for (int j = k; j < 8; j++)
                for (int i = j; i < 8; i++) begin
                    if (n == idx) begin ek = k; ej = j; ei = i; end
                    n++;
                end
    endfunction

    // LUT emulator; out-of-range indices return junk so zeroing is observable
    always_comb begin
        int ek, ej, ei, ix;
        lut_code  = 7'(lut_index(int'(lut_msb_a), int'(lut_msb_b), int'(lut_msb_c)));
        lut_dec_i = '0;
        lut_dec_j = '0;
        lut_dec_k = '0;
        for (int n = 0; n < 4; n++) begin
            ix = int'(lut_to_decode[7*n +: 7]);
            if (ix > 119) begin
                ek = 5; ej = 5; ei = 5;
            end else begin
                lut_entry(ix, ek, ej, ei);
            end
            lut_dec_i[3*n +: 3] = 3'(ei);
            lut_dec_j[3*n +: 3] = 3'(ej);
            lut_dec_k[3*n +: 3] = 3'(ek);
        end
    end

    // Model one cycle: decide grant, check DUT strobes and counters, queue response
    task automatic model_cycle();
        bit   can, any, g_enc, g_dec;
        int   w, ix, ek, ej, ei;
        rsp_t r;
        can = !m_full || rsp_ready;
        any = |enc_req_valid;
        g_enc = 0; g_dec = 0; w = 0;
        if (can) begin
            if (dec_req_valid && any) begin
                if (m_turn) g_dec = 1; else g_enc = 1;
                m_turn = !m_turn;
            end else if (dec_req_valid) g_dec = 1;
            else if (any) g_enc = 1;
            if (g_enc) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (enc_req_valid[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
                m_rr = (w + 1) % NREQ;
            end
        end
        if (dec_req_ready) dut_log.push_back(8);
        for (int i = 0; i < NREQ; i++) if (enc_req_ready[i]) dut_log.push_back(i);

        chk("enc_ready", 32'(enc_req_ready), g_enc ? (32'd1 << w) : 32'd0);
        chk("dec_ready", 32'(dec_req_ready), 32'(g_dec));
        chk("lut_encoding", 32'(lut_encoding), 32'(g_enc));
        chk("lut_decoding", 32'(lut_decoding), 32'(g_dec));
        chk("lut_msbs", 32'({lut_msb_a, lut_msb_b, lut_msb_c}), g_enc ? 32'(enc_req_msbs[9*w +: 9]) : 32'd0);
        chk("lut_to_decode", 32'(lut_to_decode), g_dec ? 32'(dec_req_idx) : 32'd0);
        chk("enc_cnt", 32'(enc_cnt), 32'(m_enc));
        chk("dec_cnt", 32'(dec_cnt), 32'(m_dec));

        if (g_enc) begin
            r.is_dec = 0; r.id = 3'(w); r.i = 0; r.j = 0; r.k = 0; r.err = 0;
            r.code = 7'(lut_index(int'(enc_req_msbs[9*w+6 +: 3]), int'(enc_req_msbs[9*w+3 +: 3]),
                                  int'(enc_req_msbs[9*w +: 3])));
            sb.push_back(r);
            if (m_enc < 65535) m_enc++;
        end
        if (g_dec) begin
            r.is_dec = 1; r.id = 0; r.code = 0; r.i = 0; r.j = 0; r.k = 0; r.err = 0;
            for (int n = 0; n < 4; n++) begin
                ix = int'(dec_req_idx[7*n +: 7]);
                if (ix >= 120) r.err[n] = 1'b1;
                else begin
                    lut_entry(ix, ek, ej, ei);
                    r.i[3*n +: 3] = 3'(ei); r.j[3*n +: 3] = 3'(ej); r.k[3*n +: 3] = 3'(ek);
                end
            end
            sb.push_back(r);
            if (m_dec < 65535) m_dec++;
        end
        m_full = g_enc || g_dec || (m_full && !rsp_ready);
    endtask

    task automatic step(input logic [NREQ-1:0] ev, input logic [NREQ*9-1:0] em,
                        input logic dv, input logic [27:0] di, input logic rr);
        @(posedge clk); #1;
        enc_req_valid = ev; enc_req_msbs = em;
        dec_req_valid = dv; dec_req_idx = di; rsp_ready = rr;
        #2;
        model_cycle();
    endtask

    function automatic logic [NREQ*9-1:0] rand_msbs();
        logic [NREQ*9-1:0] m;
        for (int i = 0; i < NREQ; i++) m[9*i +: 9] = 9'($urandom);
        return m;
    endfunction

    // Monitor: whenever the slot is valid it must match the oldest expected entry
    initial begin
        forever begin
            @(posedge clk); #2;
            if (mon_en) begin
                chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
                if (rsp_valid && sb.size() != 0) begin
                    chk("rsp_is_dec", 32'(rsp_is_dec), 32'(sb[0].is_dec));
                    chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    chk("rsp_code", 32'(rsp_code), 32'(sb[0].code));
                    chk("rsp_msb_i", 32'(rsp_msb_i), 32'(sb[0].i));
                    chk("rsp_msb_j", 32'(rsp_msb_j), 32'(sb[0].j));
                    chk("rsp_msb_k", 32'(rsp_msb_k), 32'(sb[0].k));
                    chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int exp_rr[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_ct[4]  = '{1, 8, 1, 8};
        logic [NREQ*9-1:0] m;

        repeat (2) @(posedge clk);
        #3;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_enc_cnt", 32'(enc_cnt), 32'd0);
        chk("reset_dec_cnt", 32'(dec_cnt), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Round-robin fairness with all encoders requesting
        dut_log.delete();
        for (int c = 0; c < 8; c++) step(4'hF, rand_msbs(), 1'b0, 28'd0, 1'b1);
        for (int c = 0; c < 8; c++) chk("rr_order", 32'(dut_log.size() > c ? dut_log[c] : -1), 32'(exp_rr[c]));

        // Contention between decode and encoder 1
        dut_log.delete();
        for (int c = 0; c < 4; c++) step(4'b0010, rand_msbs(), 1'b1, 28'd0, 1'b1);
        for (int c = 0; c < 4; c++) chk("contention_order", 32'(dut_log.size() > c ? dut_log[c] : -1), 32'(exp_ct[c]));

        // Directed encode (1,7,3) on requester 0
        m = '0;
        m[8:0] = {3'd1, 3'd7, 3'd3};
        step(4'b0001, m, 1'b0, 28'd0, 1'b1);
        step(4'b0000, '0, 1'b0, 28'd0, 1'b1);
        chk("enc_example_code", 32'(rsp_code), 32'd53);
        chk("enc_example_id", 32'(rsp_id), 32'd0);

        // Directed decode {119,0,53,64}
        step(4'b0000, '0, 1'b1, {7'd119, 7'd0, 7'd53, 7'd64}, 1'b1);
        step(4'b0000, '0, 1'b0, 28'd0, 1'b1);
        chk("dec_example_i", 32'(rsp_msb_i), 32'({3'd7, 3'd0, 3'd7, 3'd2}));
        chk("dec_example_j", 32'(rsp_msb_j), 32'({3'd7, 3'd0, 3'd3, 3'd2}));
        chk("dec_example_k", 32'(rsp_msb_k), 32'({3'd7, 3'd0, 3'd1, 3'd2}));
        chk("dec_example_err", 32'(rsp_err), 32'd0);

        // Out-of-range index on lane 2
        step(4'b0000, '0, 1'b1, {7'd5, 7'd120, 7'd5, 7'd5}, 1'b1);
        step(4'b0000, '0, 1'b0, 28'd0, 1'b1);
        chk("bad_idx_err", 32'(rsp_err), 32'b0100);
        chk("bad_idx_i", 32'(rsp_msb_i), 32'({3'd5, 3'd0, 3'd5, 3'd5}));
        chk("bad_idx_k", 32'(rsp_msb_k), 32'd0);

        // Backpressure: slot fills, then five stalled cycles with everyone requesting
        step(4'b0100, rand_msbs(), 1'b0, 28'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(4'hF, rand_msbs(), 1'b1, 28'd77, 1'b0);
            chk("bp_no_ready", 32'({dec_req_ready, enc_req_ready}), 32'd0);
        end

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            step(4'($urandom), rand_msbs(), ($urandom % 3) == 0, 28'($urandom),
                 ($urandom % 4) != 0);
        end

        // Reset while the slot is full
        step(4'b0001, rand_msbs(), 1'b0, 28'd0, 1'b0);
        @(posedge clk); #1;
        enc_req_valid = '0; dec_req_valid = 1'b0; rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        sb.delete();
        m_full = 0; m_rr = 0; m_turn = 0; m_enc = 0; m_dec = 0;
        #1;
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_enc_cnt", 32'(enc_cnt), 32'd0);
        chk("midreset_dec_cnt", 32'(dec_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Post-reset transaction and drain
        step(4'b1000, rand_msbs(), 1'b0, 28'd0, 1'b1);
        for (int c = 0; c < 3; c++) step(4'b0000, '0, 1'b0, 28'd0, 1'b1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
